// File: rtl/xadac_pkg.sv
// Shared widths, operand-mode encoding and request bundle for the xadac accelerator.
package xadac_pkg;

    localparam int IdWidth     = 4;
    localparam int RegIdWidth  = 5;
    localparam int VectorWidth = 128;
    localparam int ElemWidth   = 8;
    localparam int NumElems    = VectorWidth / ElemWidth;
    localparam int SumWidth    = 32;
    localparam int ProdWidth   = 17;
    localparam int PartWidth   = 21;

    typedef enum logic [1:0] {
        VDOT_UU = 2'd0,
        VDOT_SS = 2'd1,
        VDOT_US = 2'd2
    } vdot_mode_e;

    typedef struct packed {
        logic [IdWidth-1:0]     id;
        logic [RegIdWidth-1:0]  rd;
        logic [1:0]             mode;
        logic [VectorWidth-1:0] vs1;
        logic [VectorWidth-1:0] vs2;
        logic [SumWidth-1:0]    acc;
    } vdot_req_t;

    // Reserved mode 3 falls through to unsigned x unsigned.
    function automatic logic [ProdWidth-1:0] vdot_mul(input logic [ElemWidth-1:0] a,
                                                      input logic [ElemWidth-1:0] b,
                                                      input logic [1:0]           mode);
        logic               a_sx;
        logic               b_sx;
        logic signed [8:0]  a_ext;
        logic signed [8:0]  b_ext;
        logic signed [17:0] prod;
        a_sx  = (mode == VDOT_SS) && a[ElemWidth-1];
        b_sx  = ((mode == VDOT_SS) || (mode == VDOT_US)) && b[ElemWidth-1];
        a_ext = {a_sx, a};
        b_ext = {b_sx, b};
        prod  = a_ext * b_ext;
        return prod[ProdWidth-1:0];
    endfunction

endpackage

// File: rtl/xadac_vdot_tree.sv
// Combinational balanced adder tree: 16 signed 17-bit products -> 21-bit signed sum.
module xadac_vdot_tree
    import xadac_pkg::*;
(
    input  logic [NumElems*ProdWidth-1:0] prods_i,
    output logic [PartWidth-1:0]          sum_o
);

    logic [ProdWidth-1:0]   lvl0 [16];
    logic [ProdWidth:0]     lvl1 [8];
    logic [ProdWidth+1:0]   lvl2 [4];
    logic [ProdWidth+2:0]   lvl3 [2];

    // Each level sign-extends by one bit so no pair sum can overflow.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_unpack
            assign lvl0[gi] = prods_i[gi*ProdWidth +: ProdWidth];
        end
        for (gi = 0; gi < 8; gi++) begin : g_lvl1
            assign lvl1[gi] = {lvl0[2*gi][ProdWidth-1], lvl0[2*gi]}
                            + {lvl0[2*gi+1][ProdWidth-1], lvl0[2*gi+1]};
        end
        for (gi = 0; gi < 4; gi++) begin : g_lvl2
            assign lvl2[gi] = {lvl1[2*gi][ProdWidth], lvl1[2*gi]}
                            + {lvl1[2*gi+1][ProdWidth], lvl1[2*gi+1]};
        end
        for (gi = 0; gi < 2; gi++) begin : g_lvl3
            assign lvl3[gi] = {lvl2[2*gi][ProdWidth+1], lvl2[2*gi]}
                            + {lvl2[2*gi+1][ProdWidth+1], lvl2[2*gi+1]};
        end
    endgenerate

    assign sum_o = {lvl3[0][ProdWidth+2], lvl3[0]} + {lvl3[1][ProdWidth+2], lvl3[1]};

endmodule

// File: rtl/xadac_vdot.sv
// Three-stage int8 dot-product-accumulate (multiply, reduce, accumulate).
// Define XADAC_VDOT_SATURATE_EN to clamp the accumulate instead of wrapping.
module xadac_vdot
    import xadac_pkg::*;
#(
    parameter int NumStages = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [IdWidth-1:0]     req_id_i,
    input  logic [RegIdWidth-1:0]  req_rd_i,
    input  logic [1:0]             req_mode_i,
    input  logic [VectorWidth-1:0] req_vs1_i,
    input  logic [VectorWidth-1:0] req_vs2_i,
    input  logic [SumWidth-1:0]    req_acc_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [IdWidth-1:0]     rsp_id_o,
    output logic [RegIdWidth-1:0]  rsp_rd_o,
    output logic [SumWidth-1:0]    rsp_sum_o,
    output logic                   busy_o
);

    generate
        if (NumStages != 3) begin : g_bad_stages
            $fatal(1, "xadac_vdot: NumStages must be 3");
        end
    endgenerate

    vdot_req_t req;
    assign req = '{id: req_id_i, rd: req_rd_i, mode: req_mode_i,
                   vs1: req_vs1_i, vs2: req_vs2_i, acc: req_acc_i};

    logic                          s1_valid_q, s2_valid_q, s3_valid_q;
    logic [IdWidth-1:0]            s1_id_q, s2_id_q, s3_id_q;
    logic [RegIdWidth-1:0]         s1_rd_q, s2_rd_q, s3_rd_q;
    logic [SumWidth-1:0]           s1_acc_q, s2_acc_q;
    logic [NumElems*ProdWidth-1:0] s1_prod_q, s1_prod_d;
    logic [PartWidth-1:0]          s2_part_q, s2_part_d;
    logic [SumWidth-1:0]           s3_sum_q, s3_sum_d;
    logic                          s1_ready, s2_ready, s3_ready;

    // Stage k may load whenever it is empty or its downstream will take its entry.
    assign s3_ready    = !s3_valid_q || rsp_ready_i;
    assign s2_ready    = !s2_valid_q || s3_ready;
    assign s1_ready    = !s1_valid_q || s2_ready;
    assign req_ready_o = s1_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NumElems; gi++) begin : g_mul
            assign s1_prod_d[gi*ProdWidth +: ProdWidth] =
                vdot_mul(req.vs1[gi*ElemWidth +: ElemWidth],
                         req.vs2[gi*ElemWidth +: ElemWidth], req.mode);
        end
    endgenerate

    xadac_vdot_tree u_tree (
        .prods_i (s1_prod_q),
        .sum_o   (s2_part_d)
    );

`ifdef XADAC_VDOT_SATURATE_EN
    logic [SumWidth:0] sum_wide;
    assign sum_wide = {{(SumWidth+1-PartWidth){s2_part_q[PartWidth-1]}}, s2_part_q}
                    + {s2_acc_q[SumWidth-1], s2_acc_q};
    always_comb begin
        s3_sum_d = sum_wide[SumWidth-1:0];
        if (sum_wide[SumWidth] != sum_wide[SumWidth-1]) begin
            s3_sum_d = sum_wide[SumWidth] ? {1'b1, {(SumWidth-1){1'b0}}}
                                          : {1'b0, {(SumWidth-1){1'b1}}};
        end
    end
`else
    assign s3_sum_d = {{(SumWidth-PartWidth){s2_part_q[PartWidth-1]}}, s2_part_q} + s2_acc_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_rd_q    <= '0;
            s1_acc_q   <= '0;
            s1_prod_q  <= '0;
            s2_id_q    <= '0;
            s2_rd_q    <= '0;
            s2_acc_q   <= '0;
            s2_part_q  <= '0;
            s3_id_q    <= '0;
            s3_rd_q    <= '0;
            s3_sum_q   <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid_q <= req_valid_i;
                if (req_valid_i) begin
                    s1_id_q   <= req.id;
                    s1_rd_q   <= req.rd;
                    s1_acc_q  <= req.acc;
                    s1_prod_q <= s1_prod_d;
                end
            end
            if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_id_q   <= s1_id_q;
                    s2_rd_q   <= s1_rd_q;
                    s2_acc_q  <= s1_acc_q;
                    s2_part_q <= s2_part_d;
                end
            end
            if (s3_ready) begin
                s3_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    s3_id_q  <= s2_id_q;
                    s3_rd_q  <= s2_rd_q;
                    s3_sum_q <= s3_sum_d;
                end
            end
        end
    end

    assign rsp_valid_o = s3_valid_q;
    assign rsp_id_o    = s3_id_q;
    assign rsp_rd_o    = s3_rd_q;
    assign rsp_sum_o   = s3_sum_q;
    assign busy_o      = s1_valid_q || s2_valid_q || s3_valid_q;

endmodule

// File: tb/tb_xadac_vdot.sv
// Directed self-checking bench for xadac_vdot; expected sums are hand-computed.
module tb_xadac_vdot;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [3:0]   req_id_i;
    logic [4:0]   req_rd_i;
    logic [1:0]   req_mode_i;
    logic [127:0] req_vs1_i;
    logic [127:0] req_vs2_i;
    logic [31:0]  req_acc_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [3:0]   rsp_id_o;
    logic [4:0]   rsp_rd_o;
    logic [31:0]  rsp_sum_o;
    logic         busy_o;

    int checks = 0;
    int passes = 0;

    xadac_vdot dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_id_i    (req_id_i),
        .req_rd_i    (req_rd_i),
        .req_mode_i  (req_mode_i),
        .req_vs1_i   (req_vs1_i),
        .req_vs2_i   (req_vs2_i),
        .req_acc_i   (req_acc_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
        .rsp_rd_o    (rsp_rd_o),
        .rsp_sum_o   (rsp_sum_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) begin
            passes++;
            $display("check %-18s observed=%08h expected=%08h ok", tag, observed, expected);
        end else begin
            $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Request presented before edge 1; response must appear after edge 3.
    task automatic run_single(input string tag, input logic [1:0] mode,
                              input logic [127:0] vs1, input logic [127:0] vs2,
                              input logic [31:0] acc, input logic [3:0] id,
                              input logic [4:0] rd, input logic [31:0] expected);
        req_valid_i = 1'b1;
        req_mode_i  = mode;
        req_vs1_i   = vs1;
        req_vs2_i   = vs2;
        req_acc_i   = acc;
        req_id_i    = id;
        req_rd_i    = rd;
        rsp_ready_i = 1'b1;
        #1;
        chk({tag, "_rdy"}, 32'(req_ready_o), 32'd1);
        step();
        req_valid_i = 1'b0;
        chk({tag, "_v1"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd1);
        step();
        chk({tag, "_v2"}, 32'(rsp_valid_o), 32'd0);
        step();
        chk({tag, "_v3"}, 32'(rsp_valid_o), 32'd1);
        chk({tag, "_sum"}, rsp_sum_o, expected);
        chk({tag, "_id"}, 32'(rsp_id_o), 32'(id));
        chk({tag, "_rd"}, 32'(rsp_rd_o), 32'(rd));
        step();
        chk({tag, "_drain"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    function automatic logic [31:0] b2b_sum(input int k);
        return 32'(3 * (k + 1) + 1000 * k);
    endfunction

    initial begin
        logic [127:0] ones_ff;
        logic [127:0] twos;
        logic [127:0] all_80;
        logic [31:0]  ovf_exp;
        int sent;
        int got;
        int inflight;
        logic tog;
        logic saw_full;
        logic saw_rsp;

        ones_ff = {16{8'hFF}};
        twos    = {16{8'h02}};
        all_80  = {16{8'h80}};

        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_id_i    = '0;
        req_rd_i    = '0;
        req_mode_i  = '0;
        req_vs1_i   = '0;
        req_vs2_i   = '0;
        req_acc_i   = '0;
        rsp_ready_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_rsp_id", 32'(rsp_id_o), 32'd0);
        chk("rst_rsp_rd", 32'(rsp_rd_o), 32'd0);
        chk("rst_rsp_sum", rsp_sum_o, 32'd0);

        // 16 * (-1 * 2) + 100
        run_single("ss", 2'd1, ones_ff, twos, 32'd100, 4'd5, 5'd17, 32'd68);
        // 16 * 255 * 255
        run_single("uu", 2'd0, ones_ff, ones_ff, 32'd0, 4'd6, 5'd3, 32'h000FE010);
        // 16 * 128 * -128
        run_single("us", 2'd2, all_80, all_80, 32'd0, 4'd7, 5'd9, 32'hFFFC0000);
        // reserved mode behaves as unsigned
        run_single("rsv", 2'd3, ones_ff, ones_ff, 32'd0, 4'd8, 5'd31, 32'h000FE010);
`ifdef XADAC_VDOT_SATURATE_EN
        ovf_exp = 32'h7FFFFFFF;
`else
        ovf_exp = 32'h80000000;
`endif
        run_single("ovf", 2'd0, 128'd1, 128'd1, 32'h7FFFFFFF, 4'd9, 5'd1, ovf_exp);
        // 16 * (-128 * -128) - 2^31 stays negative: no clamp either way
        run_single("neg", 2'd1, all_80, all_80, 32'h80000000, 4'd10, 5'd2, 32'h80040000);

        // Back-to-back ids 0..7 with the output side stalling every other cycle.
        sent     = 0;
        got      = 0;
        inflight = 0;
        tog      = 1'b1;
        saw_full = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            rsp_ready_i = tog;
            tog         = !tog;
            req_valid_i = (sent < 8);
            req_id_i    = 4'(sent);
            req_rd_i    = 5'(sent + 8);
            req_mode_i  = 2'd0;
            req_vs1_i   = 128'(sent + 1);
            req_vs2_i   = 128'd3;
            req_acc_i   = 32'(1000 * sent);
            #1;
            chk("b2b_req_ready", 32'(req_ready_o), 32'(!(inflight == 3 && !rsp_ready_i)));
            if (inflight == 3) saw_full = 1'b1;
            if (rsp_valid_o) begin
                chk("b2b_id", 32'(rsp_id_o), 32'(got));
                chk("b2b_rd", 32'(rsp_rd_o), 32'(got + 8));
                chk("b2b_sum", rsp_sum_o, b2b_sum(got));
                if (rsp_ready_i) begin
                    got++;
                    inflight--;
                end
            end
            if (req_valid_i && req_ready_o) begin
                sent++;
                inflight++;
            end
            step();
        end
        req_valid_i = 1'b0;
        chk("b2b_all_rsp", 32'(got), 32'd8);
        chk("b2b_saw_full", 32'(saw_full), 32'd1);

        // Three entries in flight, then a one-cycle reset drops them all.
        rsp_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid_i = 1'b1;
            req_id_i    = 4'(12 + k);
            req_vs1_i   = ones_ff;
            req_vs2_i   = ones_ff;
            step();
        end
        req_valid_i = 1'b0;
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        chk("pre_rst_full", 32'(req_ready_o), 32'd0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst_ready", 32'(req_ready_o), 32'd1);
        chk("mid_rst_sum", rsp_sum_o, 32'd0);
        rsp_ready_i = 1'b1;
        saw_rsp     = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (rsp_valid_o) saw_rsp = 1'b1;
        end
        chk("mid_rst_no_rsp", 32'(saw_rsp), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/xadac_vdot.md
# xadac_vdot

Pipelined int8 dot-product-accumulate stage of the xadac accelerator. Consumes two 128-bit vector operands (16 × 8-bit elements each) plus a 32-bit accumulator, emits `acc + Σ vs1[i]·vs2[i]` tagged with transaction id and destination register. Sits directly downstream of the vector register file/load path and upstream of the xadac writeback/result arbiter; all widths come from `xadac_pkg`.

## Interface
Parameters
- `NumStages`, 3, pipeline depth; fixed at 3 (multiply, reduce, accumulate); other values rejected by elaboration assertion.

Ports
- `clk_i`  in  1  clock; sole clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when `req_valid_i && req_ready_o`.
- `req_id_i`  in  `IdWidth` (4)  transaction id.
- `req_rd_i`  in  `RegIdWidth` (5)  destination register.
- `req_mode_i`  in  2  operand signedness: 0 = uu, 1 = ss, 2 = us (vs1 unsigned, vs2 signed), 3 = reserved (treated as 0).
- `req_vs1_i`  in  `VectorWidth` (128)  operand A; element i = bits [8i+7:8i].
- `req_vs2_i`  in  `VectorWidth` (128)  operand B, same packing.
- `req_acc_i`  in  `SumWidth` (32)  accumulator seed, two's complement.
- `rsp_valid_o`  out  1  result valid.
- `rsp_ready_i`  in  1  result consumed when `rsp_valid_o && rsp_ready_i`.
- `rsp_id_o`  out  `IdWidth`  id of the request.
- `rsp_rd_o`  out  `RegIdWidth`  destination register.
- `rsp_sum_o`  out  `SumWidth`  result.
- `busy_o`  out  1  any stage holds a valid entry.

## Operation
- S1 (multiply): 16 products, each operand extended to 9 bits by `req_mode_i` (zero or sign), product held as 17-bit signed.
- S2 (reduce): balanced adder tree of 16 × 17-bit → 21-bit signed partial sum; no overflow possible.
- S3 (accumulate): sign-extend partial to 32 bits, add `acc`; default result wraps mod 2^32.
- id, rd, acc travel with the data through every stage; responses leave in request order.
- Per-stage valid bit; stage k advances when `!valid_k || ready_{k+1}`, with `ready_4 = rsp_ready_i`; bubbles collapse.
- `req_ready_o = !valid_1 || ready_2`; combinational path from `rsp_ready_i` to `req_ready_o` is permitted.
- Stalled stages hold all payload bits stable; `rsp_*` payload stable while `rsp_valid_o && !rsp_ready_i`.
- Reset: all valid bits cleared; `rsp_valid_o`=0, `busy_o`=0, `req_ready_o`=1 after reset; `rsp_id_o`/`rsp_rd_o`/`rsp_sum_o` reset to 0. Reset mid-operation discards all in-flight entries without emitting responses.

## Timing
- Latency: request accepted at edge N → `rsp_valid_o` high after edge N+3 when unstalled.
- Throughput: 1 result/cycle with `rsp_ready_i` held high.
- Full (3 entries) with `rsp_ready_i`=0: `req_ready_o`=0. Simultaneous output handshake and new request in the same cycle: both accepted.
- Empty: `busy_o`=0 and `rsp_valid_o`=0.

## Configuration
- `XADAC_VDOT_SATURATE_EN`: when defined, S3 computes a 33-bit sum and clamps to [-2^31, 2^31-1]. Undefined: 32-bit wrap. No port changes.

## Structure
- Add to `xadac_pkg`: `ProdWidth`=17, `PartWidth`=21, `vdot_mode_e` enum (UU/SS/US), and packed struct `vdot_req_t` {id, rd, mode, vs1, vs2, acc}.
- One sub-module: `xadac_vdot_tree`, purely combinational 16-input signed adder tree used by S2.

## Test plan
- mode=1, vs1 all 0xFF (-1), vs2 all 0x02, acc=100 → rsp_sum=68 at cycle 3, id/rd echoed.
- mode=0, vs1 and vs2 all 0xFF, acc=0 → 16·65025 = 1040400 (0x000FE010).
- mode=2, vs1 all 0x80 (128), vs2 all 0x80 (-128), acc=0 → -262144 (0xFFFC0000).
- acc=0x7FFFFFFF, mode=0, vs1 elem0=1, vs2 elem0=1, rest 0 → 0x80000000 without macro; 0x7FFFFFFF with `XADAC_VDOT_SATURATE_EN`.
- 8 back-to-back requests ids 0..7, `rsp_ready_i` toggled 1/0 each cycle → all 8 responses in id order, payload stable while stalled, `req_ready_o` drops only when 3 entries held.
- 3 requests in flight, assert `rst_i` one cycle → no responses, `busy_o`=0, `req_ready_o`=1 the cycle after.
